// File: rtl/div_ctrl.sv
// div_ctrl
// ---------------------------------------------------------------------------
// Control wrapper that lets an execute stage run MIPS-style DIV/DIVU on a
// multi-cycle *unsigned* divider. Signed operands are converted to
// magnitudes on the way in, and the quotient/remainder signs are restored on
// the way out. Divide-by-zero is handled locally and never reaches the
// divider. A watchdog aborts an operation whose divider never answers.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   div_req       divide request from EX, held until the result is consumed
//   div_signed    1 = DIV (signed), 0 = DIVU
//   opdata1       dividend
//   opdata2       divisor
//   annul         pipeline flush: abandon whatever is in flight
//   div_start     one-cycle start pulse to the divider
//   div_a, div_b  unsigned dividend / divisor presented to the divider
//   div_done      divider completion flag
//   div_quot      divider quotient  (valid with div_done)
//   div_rem       divider remainder (valid with div_done)
//   result        {HI = remainder, LO = quotient}
//   result_valid  result ready for HI/LO writeback
//   stall_req     stall request to the pipeline (combinational)
//   err           sticky watchdog-timeout flag, cleared only by reset
//
// Parameter
//   TIMEOUT       number of WAIT cycles allowed before the operation aborts
// ---------------------------------------------------------------------------
module div_ctrl #(
    parameter int TIMEOUT = 48
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        div_req,
    input  logic        div_signed,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        annul,
    output logic        div_start,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_done,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    output logic [63:0] result,
    output logic        result_valid,
    output logic        stall_req,
    output logic        err
);

    // Counter only has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DZERO = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        FIX   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             state_reg,  state_next;
    logic [CNT_W-1:0]   cnt_reg,    cnt_next;
    logic [31:0]        a_reg,      a_next;
    logic [31:0]        b_reg,      b_next;
    logic               sign_q_reg, sign_q_next;
    logic               sign_r_reg, sign_r_next;
    logic [31:0]        quot_reg,   quot_next;
    logic [31:0]        rem_reg,    rem_next;
    logic [63:0]        result_reg, result_next;
    logic               err_reg,    err_next;

    // -----------------------------------------------------------------------
    // Operand magnitudes (index 0 = dividend, 1 = divisor).
    // Negating 0x80000000 wraps back to 0x80000000, which is exactly the
    // unsigned magnitude 2^31, so the most-negative value needs no special
    // handling.
    // -----------------------------------------------------------------------
    logic [31:0] op_raw [2];
    logic [31:0] op_mag [2];
    logic        op_neg [2];

    assign op_raw[0] = opdata1;
    assign op_raw[1] = opdata2;

    // -----------------------------------------------------------------------
    // Sign restoration of the divider outputs (index 0 = LO/quotient,
    // 1 = HI/remainder). The remainder follows the dividend's sign, the
    // quotient is negative when exactly one operand was negative.
    // -----------------------------------------------------------------------
    logic [31:0] fix_in  [2];
    logic        fix_neg [2];
    logic [31:0] fix_out [2];

    assign fix_in[0]  = quot_reg;
    assign fix_in[1]  = rem_reg;
    assign fix_neg[0] = sign_q_reg;
    assign fix_neg[1] = sign_r_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign op_neg[gi]  = div_signed & op_raw[gi][31];
            assign op_mag[gi]  = op_neg[gi] ? (~op_raw[gi] + 32'd1) : op_raw[gi];
            assign fix_out[gi] = fix_neg[gi] ? (~fix_in[gi] + 32'd1) : fix_in[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        sign_q_next = sign_q_reg;
        sign_r_next = sign_r_reg;
        quot_next   = quot_reg;
        rem_next    = rem_reg;
        result_next = result_reg;
        err_next    = err_reg;

        if (annul) begin
            // Flush wins over everything, including a div_done arriving in
            // the same cycle; the divider answer is simply dropped.
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (div_req) begin
                        if (opdata2 == 32'd0) begin
                            state_next = DZERO;
                        end else begin
                            state_next  = ISSUE;
                            a_next      = op_mag[0];
                            b_next      = op_mag[1];
                            sign_q_next = op_neg[0] ^ op_neg[1];
                            sign_r_next = op_neg[0];
                        end
                    end
                end

                DZERO: begin
                    result_next = 64'h0;
                    state_next  = DONE;
                end

                ISSUE: begin
                    cnt_next   = '0;
                    state_next = WAIT;
                end

                WAIT: begin
                    // A completion in the last allowed cycle still counts.
                    if (div_done) begin
                        quot_next  = div_quot;
                        rem_next   = div_rem;
                        state_next = FIX;
                    end else if (cnt_reg == CNT_LAST) begin
                        err_next    = 1'b1;
                        result_next = 64'hFFFF_FFFF_FFFF_FFFF;
                        state_next  = DONE;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end

                FIX: begin
                    result_next = {fix_out[1], fix_out[0]};
                    state_next  = DONE;
                end

                DONE: begin
                    if (!div_req) begin
                        state_next = IDLE;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            a_reg      <= 32'd0;
            b_reg      <= 32'd0;
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            quot_reg   <= 32'd0;
            rem_reg    <= 32'd0;
            result_reg <= 64'd0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            sign_q_reg <= sign_q_next;
            sign_r_reg <= sign_r_next;
            quot_reg   <= quot_next;
            rem_reg    <= rem_next;
            result_reg <= result_next;
            err_reg    <= err_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // The start pulse is suppressed if a flush lands on the ISSUE cycle, so
    // a cancelled operation never occupies the divider.
    assign div_start    = (state_reg == ISSUE) & ~annul;
    assign div_a        = a_reg;
    assign div_b        = b_reg;
    assign result       = result_reg;
    assign result_valid = (state_reg == DONE);
    assign stall_req    = div_req & ~annul & (state_reg != DONE);
    assign err          = err_reg;

endmodule

// File: tb/tb_div_ctrl.sv
// Testbench for div_ctrl: directed vector table, randomized operations
// against an arithmetic reference, and hand-written flush/timeout/reset
// sequences. A small behavioural divider answers div_start after a
// configurable latency.
module tb_div_ctrl;

    logic        clk;
    logic        rst_n;
    logic        div_req;
    logic        div_signed;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic        div_start;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_done;
    logic [31:0] div_quot;
    logic [31:0] div_rem;
    logic [63:0] result;
    logic        result_valid;
    logic        stall_req;
    logic        err;

    div_ctrl #(.TIMEOUT(48)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .div_req      (div_req),
        .div_signed   (div_signed),
        .opdata1      (opdata1),
        .opdata2      (opdata2),
        .annul        (annul),
        .div_start    (div_start),
        .div_a        (div_a),
        .div_b        (div_b),
        .div_done     (div_done),
        .div_quot     (div_quot),
        .div_rem      (div_rem),
        .result       (result),
        .result_valid (result_valid),
        .stall_req    (stall_req),
        .err          (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural divider state: dv_lat = 0 means "never answers".
    int dv_lat   = 0;
    int dv_cnt   = 0;
    bit inj_done = 1'b0;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        bit          sgn;
        int          lat;
        logic [63:0] exp_res;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        bit          chk_ab;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock. Ends just after the following falling edge. The
    // divider samples div_start on the rising edge and answers dv_lat cycles
    // after the start cycle.
    task automatic cycle();
        logic nd;
        nd = 1'b0;
        #1;
        if (div_start === 1'b1 && dv_lat > 0) begin
            dv_cnt = dv_lat;
            if (div_b != 32'd0) begin
                div_quot = div_a / div_b;
                div_rem  = div_a % div_b;
            end
        end
        if (dv_cnt > 0) begin
            dv_cnt--;
            nd = (dv_cnt == 0);
        end
        if (inj_done) begin
            nd       = 1'b1;
            inj_done = 1'b0;
        end
        @(posedge clk);
        #1;
        div_done = nd;
        @(negedge clk);
    endtask

    // Reference: quotient truncates toward zero, remainder takes the sign of
    // the dividend, divide-by-zero yields 0.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit s);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [31:0] ref_mag(input logic [31:0] a, input bit s);
        longint v;
        v = s ? longint'($signed(a)) : longint'({32'd0, a});
        if (v < 0) v = -v;
        return v[31:0];
    endfunction

    // One full request/consume handshake. Operands are scrambled after the
    // request cycle to show they are not re-read.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s, input int lat,
                          output logic [63:0] res, output int lat_obs, output int starts,
                          output logic [31:0] oa, output logic [31:0] ob,
                          output logic stall0, output logic stall_done);
        opdata1    = a;
        opdata2    = b;
        div_signed = s;
        div_req    = 1'b1;
        annul      = 1'b0;
        dv_lat     = lat;
        lat_obs    = -1;
        starts     = 0;
        stall0     = 1'b0;
        stall_done = 1'b1;
        for (int c = 0; c < 120; c++) begin
            #1;
            if (c == 0) stall0 = stall_req;
            if (div_start) starts++;
            if (result_valid) begin
                lat_obs    = c;
                stall_done = stall_req;
                break;
            end
            cycle();
            opdata1    = $urandom;
            opdata2    = $urandom;
            div_signed = 1'($urandom);
        end
        res = result;
        oa  = div_a;
        ob  = div_b;
        div_req = 1'b0;
        cycle();
        #1;
    endtask

    task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input bit s, input int lat, input logic [63:0] exp_res,
                            input logic [31:0] exp_a, input logic [31:0] exp_b, input bit chk_ab);
        logic [63:0] res;
        int          lo, st;
        logic [31:0] oa, ob;
        logic        s0, sd;
        int          exp_lat;
        exp_lat = (b == 32'd0) ? 2 : lat + 3;
        run_op(a, b, s, lat, res, lo, st, oa, ob, s0, sd);
        chk({tag, "_result"}, res, exp_res);
        chk({tag, "_latency"}, lo, exp_lat);
        chk({tag, "_starts"}, st, (b == 32'd0) ? 0 : 1);
        chk({tag, "_stall_req_cycle"}, s0, 1'b1);
        chk({tag, "_stall_done"}, sd, 1'b0);
        chk({tag, "_valid_drop"}, result_valid, 1'b0);
        if (chk_ab) begin
            chk({tag, "_div_a"}, oa, exp_a);
            chk({tag, "_div_b"}, ob, exp_b);
        end
        $display("txn %s: op1=%h op2=%h signed=%0d lat=%0d result=%h valid_after=%0d starts=%0d",
                 tag, a, b, s, lat, res, lo, st);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit          rs;
        int          rl, cnt, t_issue;

        vecs[0] = '{32'd100,        32'd7,          1'b0, 33, {32'd2,          32'd14},         32'd100,        32'd7,          1'b1};
        vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 5,  {32'hFFFF_FFFF,  32'hFFFF_FFFD},  32'd7,          32'd2,          1'b1};
        vecs[2] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 12, {32'd0,          32'h8000_0000},  32'h8000_0000,  32'd1,          1'b1};
        vecs[3] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 3,  {32'd1,          32'hFFFF_FFFD},  32'd7,          32'd2,          1'b1};
        vecs[4] = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 1,  {32'hFFFF_FFFF,  32'd3},          32'd7,          32'd2,          1'b1};
        vecs[5] = '{32'hFFFF_FFFF,  32'h10,         1'b0, 8,  {32'hF,          32'h0FFF_FFFF},  32'hFFFF_FFFF,  32'h10,         1'b1};
        vecs[6] = '{32'h1234_5678,  32'd0,          1'b1, 4,  64'd0,                            32'd0,          32'd0,          1'b0};
        vecs[7] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 2,  {32'h8000_0000,  32'd0},          32'h8000_0000,  32'hFFFF_FFFF,  1'b1};
        vecs[8] = '{32'hFFFF_FFF9,  32'd2,          1'b0, 48, {32'd1,          32'h7FFF_FFFC},  32'hFFFF_FFF9,  32'd2,          1'b1};
        vecs[9] = '{32'd0,          32'd0,          1'b0, 4,  64'd0,                            32'd0,          32'd0,          1'b0};

        rst_n      = 1'b0;
        div_req    = 1'b1;
        div_signed = 1'b0;
        opdata1    = 32'd0;
        opdata2    = 32'd0;
        annul      = 1'b0;
        div_done   = 1'b0;
        div_quot   = 32'd0;
        div_rem    = 32'd0;

        // Reset state; stall_req still follows div_req with state IDLE.
        @(negedge clk);
        #1;
        chk("rst_stall_req", stall_req, 1'b1);
        chk("rst_result_valid", result_valid, 1'b0);
        chk("rst_div_start", div_start, 1'b0);
        chk("rst_result", result, 64'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_div_a", div_a, 32'd0);
        annul = 1'b1;
        #1;
        chk("rst_stall_annul", stall_req, 1'b0);
        div_req = 1'b0;
        annul   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            check_op($sformatf("vec%0d", i), vecs[i].op1, vecs[i].op2, vecs[i].sgn, vecs[i].lat,
                     vecs[i].exp_res, vecs[i].exp_a, vecs[i].exp_b, vecs[i].chk_ab);
        end
        chk("err_after_table", err, 1'b0);

        // Randomized operations against the arithmetic reference.
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            rl = $urandom_range(1, 48);
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = $urandom_range(1, 16);
                3: rb = 32'hFFFF_FFFF - $urandom_range(0, 15);
                default: ;
            endcase
            check_op($sformatf("rnd%0d", i), ra, rb, rs, rl, ref_div(ra, rb, rs),
                     ref_mag(ra, rs), ref_mag(rb, rs), rb != 32'd0);
        end

        // Stray div_done while idle must be ignored.
        div_quot = 32'hDEAD_BEEF;
        div_rem  = 32'hCAFE_F00D;
        inj_done = 1'b1;
        cycle();
        cycle();
        #1;
        chk("stray_idle_valid", result_valid, 1'b0);
        chk("stray_idle_start", div_start, 1'b0);

        // Stray div_done while in DONE must not disturb the held result.
        opdata1 = 32'd100; opdata2 = 32'd7; div_signed = 1'b0; div_req = 1'b1; dv_lat = 2;
        cnt = 0;
        while (cnt < 20) begin
            #1;
            if (result_valid) break;
            cycle();
            cnt++;
        end
        chk("stray_done_reach", cnt, 5);
        div_quot = 32'h1111_1111;
        div_rem  = 32'h2222_2222;
        inj_done = 1'b1;
        cycle();
        cycle();
        #1;
        chk("stray_done_result", result, {32'd2, 32'd14});
        chk("stray_done_valid", result_valid, 1'b1);
        div_req = 1'b0;
        cycle();

        // Flush on the ISSUE cycle: no start pulse, back to IDLE.
        opdata1 = 32'd20; opdata2 = 32'd3; div_signed = 1'b0; div_req = 1'b1; dv_lat = 3;
        cycle();
        annul = 1'b1;
        #1;
        chk("annul_issue_start", div_start, 1'b0);
        cycle();
        annul = 1'b0; div_req = 1'b0;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (result_valid || div_start || stall_req) cnt++;
            cycle();
        end
        chk("annul_issue_quiet", cnt, 0);

        // Flush in WAIT, divider answers 5 cycles later: answer is dropped.
        opdata1 = 32'd1000; opdata2 = 32'd10; div_signed = 1'b0; div_req = 1'b1; dv_lat = 7;
        cycle(); cycle(); cycle();
        annul = 1'b1;
        #1;
        chk("annul_wait_stall", stall_req, 1'b0);
        cycle();
        annul = 1'b0; div_req = 1'b0;
        #1;
        chk("annul_wait_next_valid", result_valid, 1'b0);
        chk("annul_wait_next_stall", stall_req, 1'b0);
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (result_valid) cnt++;
            cycle();
        end
        chk("annul_wait_no_valid", cnt, 0);
        check_op("post_annul", 32'hFFFF_FF9C, 32'd7, 1'b1, 6, ref_div(32'hFFFF_FF9C, 32'd7, 1'b1),
                 32'd100, 32'd7, 1'b1);

        // Watchdog: divider never answers.
        opdata1 = 32'd50; opdata2 = 32'd5; div_signed = 1'b0; div_req = 1'b1; dv_lat = 0;
        t_issue = -1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (div_start) begin
                t_issue = c;
                break;
            end
            cycle();
        end
        chk("to_issue_cycle", t_issue, 1);
        repeat (48) cycle();
        #1;
        chk("to_err_before", err, 1'b0);
        chk("to_valid_before", result_valid, 1'b0);
        cycle();
        #1;
        chk("to_err", err, 1'b1);
        chk("to_valid", result_valid, 1'b1);
        chk("to_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        div_req = 1'b0;
        cycle();
        check_op("after_to", 32'd81, 32'd9, 1'b0, 4, {32'd0, 32'd9}, 32'd81, 32'd9, 1'b1);
        chk("err_sticky", err, 1'b1);

        // Asynchronous reset in the middle of WAIT.
        opdata1 = 32'hFFFF_0000; opdata2 = 32'd3; div_signed = 1'b1; div_req = 1'b1; dv_lat = 0;
        repeat (5) cycle();
        #2;
        rst_n   = 1'b0;
        div_req = 1'b0;
        #1;
        chk("arst_div_start", div_start, 1'b0);
        chk("arst_div_a", div_a, 32'd0);
        chk("arst_div_b", div_b, 32'd0);
        chk("arst_result", result, 64'd0);
        chk("arst_valid", result_valid, 1'b0);
        chk("arst_err", err, 1'b0);
        chk("arst_stall", stall_req, 1'b0);
        dv_cnt   = 0;
        div_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check_op("post_rst", 32'd100, 32'd7, 1'b0, 33, {32'd2, 32'd14}, 32'd100, 32'd7, 1'b1);
        chk("post_rst_err", err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 48, max WAIT cycles before abort.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 div_req  input  1  EX-stage divide request, held high until result consumed.
REQ-005 div_signed  input  1  1 = DIV (signed), 0 = DIVU.
REQ-006 opdata1  input  32  dividend.
REQ-007 opdata2  input  32  divisor.
REQ-008 annul  input  1  cancel in-flight operation (flush).
REQ-009 div_start  output  1  one-cycle start pulse to unsigned divider.
REQ-010 div_a  output  32  unsigned dividend to divider.
REQ-011 div_b  output  32  unsigned divisor to divider.
REQ-012 div_done  input  1  divider completion flag.
REQ-013 div_quot  input  32  divider quotient, valid with div_done.
REQ-014 div_rem  input  32  divider remainder, valid with div_done.
REQ-015 result  output  64  {HI=remainder, LO=quotient}.
REQ-016 result_valid  output  1  result ready for HI/LO writeback.
REQ-017 stall_req  output  1  pipeline stall request.
REQ-018 err  output  1  sticky timeout flag.

Function
REQ-019 States SHALL be IDLE, DZERO, ISSUE, WAIT, FIX, DONE; encoded registered FSM.
REQ-020 IDLE: div_req=1, annul=0, opdata2==0 -> DZERO; div_req=1, annul=0, opdata2!=0 -> ISSUE; else stay.
REQ-021 On leaving IDLE to ISSUE, SHALL latch div_a/div_b = |opdata| when div_signed and operand bit31=1, else raw operand; latch sign_q = signed & (op1[31]^op2[31]), sign_r = signed & op1[31].
REQ-022 0x80000000 magnitude SHALL pass as unsigned 0x80000000 (no overflow trap).
REQ-023 ISSUE: div_start=1 for exactly one cycle, reset WAIT counter to 0, -> WAIT.
REQ-024 WAIT: div_done=1 -> latch div_quot/div_rem, -> FIX; counter reaching TIMEOUT-1 without div_done -> set err, result=64'hFFFFFFFF_FFFFFFFF, -> DONE.
REQ-025 FIX: LO = sign_q ? -quot : quot; HI = sign_r ? -rem : rem (32-bit two's complement, wrap); -> DONE.
REQ-026 DZERO: result=64'h0, div_start never asserted, -> DONE next cycle.
REQ-027 DONE: result_valid=1 and result held stable while div_req=1; div_req=0 -> IDLE, result_valid=0 next cycle.
REQ-028 stall_req SHALL be combinational: div_req & ~annul & (state != DONE).
REQ-029 annul=1 in any state SHALL force IDLE next cycle, result_valid=0, div_start=0; divider output arriving later SHALL be ignored.
REQ-030 div_done while not in WAIT SHALL be ignored.
REQ-031 Latency req-to-result_valid: divider latency + 3 cycles (ISSUE, FIX, DONE entry); DZERO path 2 cycles.
REQ-032 Operand changes after IDLE exit SHALL not affect result.
REQ-033 err SHALL remain 1 until reset.

Reset
REQ-034 rst_n=0 SHALL asynchronously force IDLE, div_start=0, div_a=0, div_b=0, result=0, result_valid=0, err=0, counter=0.
REQ-035 Reset mid-operation SHALL discard all latched state; first post-reset div_req starts clean.
REQ-036 stall_req during reset SHALL follow REQ-028 with state=IDLE.

Verification
REQ-037 DIVU 100/7, divider done after 33 cycles -> result_valid with LO=14, HI=2; one div_start pulse.
REQ-038 DIV -7/2 -> div_a=7, div_b=2; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-039 DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0; err=0.
REQ-040 any/0 -> result=0, result_valid 2 cycles after req, div_start never high.
REQ-041 annul asserted in WAIT, div_done 5 cycles later -> IDLE next cycle, result_valid stays 0, stall_req=0.
REQ-042 div_done held low, TIMEOUT=48 -> err=1 and result all-ones 48 cycles after ISSUE; rst_n low mid-WAIT -> all outputs zero immediately.
